// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-monitor unit: FSM state,
// default widths, event channel indices and the counter step helper.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } perf_state_t;

    localparam int NUM_CH_DEF    = 4;
    localparam int CNT_W_DEF     = 32;
    localparam int WRAP_MODE_DEF = 1;
    localparam int SEL_W_DEF     = 5;
    localparam int CNT_W_MAX     = 64;

    localparam int CH_INST  = 0;
    localparam int CH_ICREQ = 1;
    localparam int CH_ICHIT = 2;
    localparam int CH_DCREQ = 3;

    // Next counter value for one increment request; at_max marks an all-ones counter.
    function automatic logic [CNT_W_MAX-1:0] ctr_step(
        input logic [CNT_W_MAX-1:0] cnt,
        input logic                 at_max,
        input logic                 inc,
        input logic                 wrap
    );
        if (!inc) begin
            return cnt;
        end
        if (!at_max) begin
            return cnt + 64'd1;
        end
        return wrap ? '0 : cnt;
    endfunction

endpackage

// File: rtl/perf_ctr_slice.sv
// One CNT_W event counter with synchronous clear, wrap or saturate behaviour
// and a sticky overflow flag.
module perf_ctr_slice
    import perf_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int WRAP_MODE = WRAP_MODE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic at_max;

    assign at_max = &cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= CNT_W'(ctr_step(CNT_W_MAX'(cnt), at_max, inc, WRAP_MODE != 0));
            if (inc && at_max) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_event_counter.sv
// Performance-monitor unit: free cycle counter plus NUM_CH event channels, halt freeze
// and a registered indexed read port. Shadow-bank snapshot is enabled by PERF_SNAPSHOT_EN.
//
// state  | meaning
// IDLE   | not counting, waiting for en
// RUN    | cycle counter and event channels counting
// FROZEN | halted; counts held until clear
module perf_event_counter
    import perf_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int WRAP_MODE = WRAP_MODE_DEF,
    parameter int SEL_W     = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              halt,
    input  logic [NUM_CH-1:0] evt,
    input  logic [SEL_W-1:0]  rd_sel,
`ifdef PERF_SNAPSHOT_EN
    input  logic              snap,
    output logic              snap_valid,
`endif
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH:0]   ovf,
    output logic              frozen
);

    localparam int NS = NUM_CH + 1;

    perf_state_t      state;
    perf_state_t      next_state;
    logic             count_en;
    logic [NS-1:0]    inc;
    logic [CNT_W-1:0] cnt [NS];
    logic [CNT_W-1:0] rd_mux;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            frozen <= 1'b0;
        end else begin
            state  <= next_state;
            frozen <= (next_state == FROZEN);
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = en ? RUN : IDLE;
        end else begin
            case (state)
                IDLE:    if (en) next_state = RUN;
                RUN: begin
                    if (halt)     next_state = FROZEN;
                    else if (!en) next_state = IDLE;
                end
                FROZEN:  next_state = FROZEN;
                default: next_state = IDLE;
            endcase
        end
    end

    // The clear cycle never counts, even when the FSM sits in RUN.
    always_comb begin
        count_en = (state == RUN) && !clear;
    end

    assign inc = {count_en, evt & {NUM_CH{count_en}}};

    for (genvar g = 0; g < NS; g++) begin : g_slice
        perf_ctr_slice #(
            .CNT_W     (CNT_W),
            .WRAP_MODE (WRAP_MODE)
        ) u_slice (
            .clk (clk),
            .rst (rst),
            .inc (inc[g]),
            .clr (clear),
            .cnt (cnt[g]),
            .ovf (ovf[g])
        );
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow [NS];
    logic             frz_entry;

    assign frz_entry = (state != FROZEN) && (next_state == FROZEN);

    // Shadow captures the same post-increment value each slice is about to load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_valid <= 1'b0;
            for (int i = 0; i < NS; i++) shadow[i] <= '0;
        end else if (clear) begin
            snap_valid <= 1'b0;
        end else if (snap || frz_entry) begin
            snap_valid <= 1'b1;
            for (int i = 0; i < NS; i++) begin
                shadow[i] <= CNT_W'(ctr_step(CNT_W_MAX'(cnt[i]), &cnt[i], inc[i], WRAP_MODE != 0));
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NS; i++) begin
            if (rd_sel == SEL_W'(i)) rd_mux = snap_valid ? shadow[i] : cnt[i];
        end
    end
`else
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NS; i++) begin
            if (rd_sel == SEL_W'(i)) rd_mux = cnt[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: wrap and saturate instances (CNT_W=8) driven in parallel,
// directed scenarios with literal expectations, then randomized traffic against a totals-based model.
`timescale 1ns/1ps
module tb_perf_event_counter;

    localparam int     NCH  = 4;
    localparam int     CW   = 8;
    localparam longint MAXV = 255;

    logic           clk;
    logic           rst;
    logic           en;
    logic           clear;
    logic           halt;
    logic [NCH-1:0] evt;
    logic [4:0]     rd_sel;
    logic [CW-1:0]  rd_w, rd_s;
    logic [NCH:0]   ovf_w, ovf_s;
    logic           frz_w, frz_s;
`ifdef PERF_SNAPSHOT_EN
    logic           snap;
    logic           sv_w, sv_s;
`endif

    int checks = 0;
    int errors = 0;
    bit go = 0;

    perf_event_counter #(.NUM_CH(NCH), .CNT_W(CW), .WRAP_MODE(1), .SEL_W(5)) dut_w (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .halt(halt), .evt(evt), .rd_sel(rd_sel),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap), .snap_valid(sv_w),
`endif
        .rd_data(rd_w), .ovf(ovf_w), .frozen(frz_w)
    );

    perf_event_counter #(.NUM_CH(NCH), .CNT_W(CW), .WRAP_MODE(0), .SEL_W(5)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .halt(halt), .evt(evt), .rd_sel(rd_sel),
`ifdef PERF_SNAPSHOT_EN
        .snap(snap), .snap_valid(sv_s),
`endif
        .rd_data(rd_s), .ovf(ovf_s), .frozen(frz_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: true event totals since the last clear; counter views derived by arithmetic.
    typedef enum int {M_IDLE, M_RUN, M_FROZEN} mstate_t;
    mstate_t mst = M_IDLE;
    longint  tot [NCH+1];
    longint  shd [NCH+1];
    bit      m_sv = 0;
    longint  exp_rd_w = 0;
    longint  exp_rd_s = 0;

    function automatic longint view(input longint t, input bit wrap);
        if (wrap) return t % (MAXV + 1);
        return (t > MAXV) ? MAXV : t;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i <= NCH; i++) begin
            tot[i] = 0;
            shd[i] = 0;
        end
        m_sv = 0;
        mst = M_IDLE;
        exp_rd_w = 0;
        exp_rd_s = 0;
    endfunction

    function automatic void model_step();
        longint src;
`ifdef PERF_SNAPSHOT_EN
        mstate_t prev;
        prev = mst;
`endif
        src = 0;
        if (int'(rd_sel) <= NCH) src = m_sv ? shd[rd_sel] : tot[rd_sel];
        exp_rd_w = view(src, 1'b1);
        exp_rd_s = view(src, 1'b0);
        if (clear) begin
            for (int i = 0; i <= NCH; i++) tot[i] = 0;
            m_sv = 0;
            mst = en ? M_RUN : M_IDLE;
        end else begin
            if (mst == M_RUN) begin
                tot[NCH]++;
                for (int i = 0; i < NCH; i++) if (evt[i]) tot[i]++;
            end
            case (mst)
                M_IDLE: if (en) mst = M_RUN;
                M_RUN: begin
                    if (halt) mst = M_FROZEN;
                    else if (!en) mst = M_IDLE;
                end
                default: ;
            endcase
`ifdef PERF_SNAPSHOT_EN
            if (snap || (prev != M_FROZEN && mst == M_FROZEN)) begin
                shd = tot;
                m_sv = 1;
            end
`endif
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (go) begin
            logic [NCH:0] eo;
            for (int i = 0; i <= NCH; i++) eo[i] = (tot[i] > MAXV);
            chk("rd_wrap", rd_w, exp_rd_w);
            chk("rd_sat", rd_s, exp_rd_s);
            chk("ovf_wrap", ovf_w, eo);
            chk("ovf_sat", ovf_s, eo);
            chk("frozen_wrap", frz_w, longint'(mst == M_FROZEN));
            chk("frozen_sat", frz_s, longint'(mst == M_FROZEN));
`ifdef PERF_SNAPSHOT_EN
            chk("snapv_wrap", sv_w, longint'(m_sv));
            chk("snapv_sat", sv_s, longint'(m_sv));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_rd(input string name, input longint ew, input longint es);
        chk({name, "_wrap"}, rd_w, ew);
        chk({name, "_sat"}, rd_s, es);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clear = 1'b0; halt = 1'b0; evt = '0; rd_sel = '0;
`ifdef PERF_SNAPSHOT_EN
        snap = 1'b0;
`endif
        repeat (3) cyc();
        chk_rd("reset_rd", 0, 0);
        chk("reset_ovf", {ovf_w, ovf_s}, 0);
        chk("reset_frozen", {frz_w, frz_s}, 0);
        rst = 1'b1;
        cyc();
        go = 1;

        // First en edge only leaves IDLE; the next ten count. The en=0 edge is still a RUN cycle.
        en = 1'b1; evt = 4'b0001; rd_sel = 5'd0;
        repeat (11) cyc();
        en = 1'b0; evt = '0;
        cyc();
        chk_rd("t1_ch0", 10, 10);
        rd_sel = 5'd4;
        cyc();
        chk_rd("t1_cycles", 11, 11);
        chk("t1_ovf", {ovf_w, ovf_s}, 0);

        // 300 pulses on channel 1 in an 8-bit counter.
        clear = 1'b1; en = 1'b1;
        cyc();
        clear = 1'b0; evt = 4'b0010;
        repeat (300) cyc();
        en = 1'b0; evt = '0; rd_sel = 5'd1;
        cyc();
        chk_rd("t2_ch1", 44, 255);
        chk("t2_ovf1_wrap", ovf_w[1], 1);
        chk("t2_ovf1_sat", ovf_s[1], 1);

        // Halt on the fifth counting cycle; later events are dropped.
        clear = 1'b1; en = 1'b1;
        cyc();
        clear = 1'b0; evt = 4'b1111;
        repeat (4) cyc();
        halt = 1'b1;
        cyc();
        chk("t3_frozen_rise", {frz_w, frz_s}, 2'b11);
        halt = 1'b0;
        repeat (5) cyc();
        chk("t3_frozen_hold", {frz_w, frz_s}, 2'b11);
        evt = '0;
        for (int i = 0; i < NCH; i++) begin
            rd_sel = 5'(i);
            cyc();
            chk_rd("t3_ch", 5, 5);
        end

        // clear beats halt; en in the same cycle goes straight to RUN.
        clear = 1'b1; halt = 1'b1; en = 1'b1; evt = 4'b1111;
        cyc();
        chk("t4_frozen", {frz_w, frz_s}, 0);
        chk("t4_ovf", {ovf_w, ovf_s}, 0);
        clear = 1'b0; halt = 1'b0; en = 1'b0; evt = '0; rd_sel = 5'd0;
        cyc();
        chk_rd("t4_ch0", 0, 0);
        rd_sel = 5'd4;
        cyc();
        chk_rd("t4_run_cycle", 1, 1);

        // Asynchronous reset between edges while frozen with an overflowed cycle counter.
        clear = 1'b1; en = 1'b1;
        cyc();
        clear = 1'b0;
        for (int n = 0; n < 260; n++) begin
            evt = 4'($urandom);
            cyc();
        end
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        cyc();
        chk("t5_pre_frozen", {frz_w, frz_s}, 2'b11);
        chk("t5_pre_ovf_cyc", {ovf_w[4], ovf_s[4]}, 2'b11);
        #2;
        rst = 1'b0;
        #1;
        chk_rd("t5_rst_rd", 0, 0);
        chk("t5_rst_ovf", {ovf_w, ovf_s}, 0);
        chk("t5_rst_frozen", {frz_w, frz_s}, 0);
        cyc();
        rst = 1'b1; en = 1'b1; evt = 4'b0001; rd_sel = 5'd0;
        repeat (4) cyc();
        en = 1'b0; evt = '0;
        cyc();
        chk_rd("t5_restart", 3, 3);

`ifdef PERF_SNAPSHOT_EN
        clear = 1'b1; en = 1'b1;
        cyc();
        clear = 1'b0; evt = 4'b0001;
        repeat (7) cyc();
        evt = '0; snap = 1'b1;
        cyc();
        snap = 1'b0; evt = 4'b0001;
        repeat (3) cyc();
        en = 1'b0; evt = '0; rd_sel = 5'd0;
        cyc();
        chk_rd("t6_snap_rd", 7, 7);
        chk("t6_snapv", {sv_w, sv_s}, 2'b11);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t6_snapv_clear", {sv_w, sv_s}, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            en     = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 24) == 0);
            halt   = ($urandom_range(0, 49) == 0);
            evt    = 4'($urandom);
            rd_sel = 5'($urandom);
`ifdef PERF_SNAPSHOT_EN
            snap   = ($urandom_range(0, 29) == 0);
`endif
            if ($urandom_range(0, 399) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                chk_rd("rand_rst_rd", 0, 0);
                chk("rand_rst_ovf", {ovf_w, ovf_s}, 0);
                cyc();
                rst = 1'b1;
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
